// File: rtl/ddr_test_pkg.sv
// Definitions shared by the DDR self-test write generator and read checker, so both
// ends build AXI fields and per-lane beat data from the same source.
package ddr_test_pkg;

  localparam logic [2:0]  AXI_SIZE_64    = 3'b011;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [63:0] PATTERN_01     = 64'h0000_ffff_0000_ffff;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  // Upper byte carries the random byte; lower byte keys it to the beat address so a
  // misplaced beat is detectable by the reader.
  function automatic logic [15:0] lane_data(input logic [7:0] rnd,
                                            input logic [7:0] base,
                                            input logic [1:0] lane);
    return {rnd, rnd ^ (base + {6'd0, lane})};
  endfunction

endpackage

// File: rtl/test_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that steps only when enabled.
module test_lfsr8 #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [7:0] rnd_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[7:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 8'hB8;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q;

endmodule

// File: rtl/test_wr_ctrl_64bit.sv
// AXI write-side traffic generator for the DDR3 self-test: one INCR burst per write_en,
// address-keyed self-checking data, and B-response error tracking.
module test_wr_ctrl_64bit
  import ddr_test_pkg::*;
#(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 16,
  parameter logic [7:0] LFSR_SEED       = 8'h5A
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       write_en,
  input  logic                       data_pattern_01,
  output logic                       write_done_p,
  output logic [31:0]                axi_awaddr,
  output logic [7:0]                 axi_awid,
  output logic [7:0]                 axi_awlen,
  output logic [2:0]                 axi_awsize,
  output logic [1:0]                 axi_awburst,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [63:0]                axi_wdata,
  output logic [7:0]                 axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  input  logic [7:0]                 axi_bid,
  input  logic [1:0]                 axi_bresp,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  output logic [7:0]                 err_cnt,
  output logic                       err_flag_led
);

  localparam int DQ_NUM = MEM_DQ_WIDTH / 16;

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  awid_q, awid_d;
  logic [3:0]  awlen_q, awlen_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  base_q, base_d;
  logic        pat_q, pat_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        lfsr_step;
  logic        done;
  logic        wlast;
  logic [7:0]  rnd;
  logic [63:0] beat_data;
  logic [16*DQ_NUM-1:0] lane_rep;

  test_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .step_i (lfsr_step),
    .rnd_o  (rnd)
  );

  assign wlast = wvalid_q && (beat_cnt_q == awlen_q);

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awid_d     = awid_q;
    awlen_d    = awlen_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    beat_cnt_d = beat_cnt_q;
    base_d     = base_q;
    pat_d      = pat_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    lfsr_step  = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (write_en) begin
          awaddr_d   = 32'({random_rw_addr, 1'b0});
          awid_d     = random_axi_id;
          awlen_d    = random_axi_len;
          base_d     = random_rw_addr[7:0];
          pat_d      = data_pattern_01;
          beat_cnt_d = 4'd0;
          awvalid_d  = 1'b1;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (axi_wready) begin
          lfsr_step  = 1'b1;
          beat_cnt_d = beat_cnt_q + 4'd1;
          base_d     = base_q + 8'd4;
          if (wlast) begin
            wvalid_d = 1'b0;
            state_d  = ST_B;
          end
        end
      end
      ST_B: begin
        if (axi_bvalid) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          // Bad response: either non-OKAY or an ID that does not match the issued burst.
          if ((axi_bresp != AXI_RESP_OKAY) || (axi_bid != {4'd0, awid_q})) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      awaddr_q   <= '0;
      awid_q     <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      beat_cnt_q <= '0;
      base_q     <= '0;
      pat_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awid_q     <= awid_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      beat_cnt_q <= beat_cnt_d;
      base_q     <= base_d;
      pat_q      <= pat_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    beat_data = '0;
    lane_rep  = '0;
    for (int i = 0; i < 4; i++) begin
      lane_rep = {DQ_NUM{lane_data(rnd, base_q, 2'(i))}};
      beat_data[16*i +: 16] = lane_rep[15:0];
    end
  end

  // Data is forced to zero outside a W beat so idle/reset outputs are all-zero.
  assign axi_wdata    = wvalid_q ? (pat_q ? PATTERN_01 : beat_data) : 64'd0;
  assign axi_wlast    = wlast;
  assign axi_wvalid   = wvalid_q;
  assign axi_wstrb    = 8'hFF;
  assign axi_awaddr   = awaddr_q;
  assign axi_awid     = {4'd0, awid_q};
  assign axi_awlen    = {4'd0, awlen_q};
  assign axi_awsize   = AXI_SIZE_64;
  assign axi_awburst  = AXI_BURST_INCR;
  assign axi_awvalid  = awvalid_q;
  assign axi_bready   = 1'b1;
  assign write_done_p = done;
  assign err_cnt      = err_cnt_q;
  assign err_flag_led = err_flag_q;

endmodule

// File: tb/tb_test_wr_ctrl_64bit.sv
// Bench for test_wr_ctrl_64bit: table of directed bursts plus hand sequences for
// error saturation and mid-burst reset.
module tb_test_wr_ctrl_64bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] random_rw_addr = '0;
  logic [3:0]  random_axi_id = '0;
  logic [3:0]  random_axi_len = '0;
  logic        write_en = 1'b0;
  logic        data_pattern_01 = 1'b0;
  logic        write_done_p;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awid, axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready = 1'b0;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid;
  logic        axi_wready = 1'b0;
  logic [7:0]  axi_bid = '0;
  logic [1:0]  axi_bresp = '0;
  logic        axi_bvalid = 1'b0;
  logic        axi_bready;
  logic [7:0]  err_cnt;
  logic        err_flag_led;

  test_wr_ctrl_64bit dut (
    .clk(clk), .rst(rst),
    .random_rw_addr(random_rw_addr), .random_axi_id(random_axi_id),
    .random_axi_len(random_axi_len), .write_en(write_en),
    .data_pattern_01(data_pattern_01), .write_done_p(write_done_p),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .err_cnt(err_cnt), .err_flag_led(err_flag_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic        pat;
    int          awdly;
    logic        wrand;
    logic [1:0]  bresp;
    logic        bidbad;
    logic [31:0] exp_awaddr;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] m_lfsr = 8'h5A;
  logic [7:0] m_err  = 8'h00;
  logic       m_flag = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1, right-shifting Galois form.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'b1011_1000;
    return n;
  endfunction

  function automatic logic [63:0] exp_data(input logic [7:0] rnd, input logic [7:0] base,
                                           input logic pat);
    logic [63:0] d;
    if (pat) return 64'h0000_ffff_0000_ffff;
    d = '0;
    for (int i = 0; i < 4; i++) d[16*i +: 16] = {rnd, rnd ^ (base + 8'(i))};
    return d;
  endfunction

  task automatic start_burst(input vec_t v);
    @(negedge clk);
    random_rw_addr  = v.addr;
    random_axi_id   = v.id;
    random_axi_len  = v.len;
    data_pattern_01 = v.pat;
    write_en        = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    chk("awvalid_latency", 64'(axi_awvalid), 64'd1);
    chk("awaddr", 64'(axi_awaddr), 64'(v.exp_awaddr));
    chk("awid", 64'(axi_awid), {56'd0, 4'd0, v.id});
    chk("awlen", 64'(axi_awlen), {56'd0, 4'd0, v.len});
    chk("awsize", 64'(axi_awsize), 64'd3);
    chk("awburst", 64'(axi_awburst), 64'd1);
    chk("wvalid_before_aw", 64'(axi_wvalid), 64'd0);
    for (int k = 0; k < v.awdly; k++) begin
      @(negedge clk);
      chk("awvalid_hold", 64'(axi_awvalid), 64'd1);
      chk("awaddr_hold", 64'(axi_awaddr), 64'(v.exp_awaddr));
      chk("awlen_hold", 64'(axi_awlen), {56'd0, 4'd0, v.len});
      chk("wvalid_stall_aw", 64'(axi_wvalid), 64'd0);
    end
    axi_awready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0;
    chk("awvalid_drop", 64'(axi_awvalid), 64'd0);
    chk("wvalid_latency", 64'(axi_wvalid), 64'd1);
  endtask

  // Runs one W beat; stalls on wready if requested. Returns data seen.
  task automatic do_beat(input vec_t v, input int b, inout logic [7:0] base,
                         output logic [63:0] seen, output logic ok);
    logic hs;
    hs   = 1'b0;
    seen = '0;
    for (int g = 0; g < 200 && !hs; g++) begin
      chk("wvalid", 64'(axi_wvalid), 64'd1);
      chk("wdata", axi_wdata, exp_data(m_lfsr, base, v.pat));
      chk("wlast", 64'(axi_wlast), 64'(b == int'(v.len)));
      seen = axi_wdata;
      axi_wready = v.wrand ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = axi_wready;
      @(negedge clk);
    end
    axi_wready = 1'b0;
    ok = hs;
    if (!hs) chk("w_handshake_timeout", 64'd0, 64'd1);
    else begin
      m_lfsr = lfsr_next(m_lfsr);
      base   = base + 8'd4;
    end
  endtask

  task automatic do_burst(input vec_t v, output logic [63:0] c0, output logic [63:0] c1);
    logic [7:0]  base;
    logic [63:0] seen;
    logic        ok;
    logic        bad;
    base = v.addr[7:0];
    c0 = '0;
    c1 = '0;
    start_burst(v);
    for (int b = 0; b <= int'(v.len); b++) begin
      do_beat(v, b, base, seen, ok);
      if (!ok) return;
      if (b == 0) c0 = seen;
      if (b == 1) c1 = seen;
    end
    chk("wvalid_after_last", 64'(axi_wvalid), 64'd0);
    chk("done_before_b", 64'(write_done_p), 64'd0);
    axi_bvalid = 1'b1;
    axi_bresp  = v.bresp;
    axi_bid    = {4'd0, v.id} ^ (v.bidbad ? 8'h01 : 8'h00);
    #1;
    chk("done_pulse", 64'(write_done_p), 64'd1);
    @(negedge clk);
    axi_bvalid = 1'b0;
    #1;
    chk("done_one_cycle", 64'(write_done_p), 64'd0);
    bad = (v.bresp != 2'b00) || v.bidbad;
    if (bad) begin
      m_flag = 1'b1;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("err_flag", 64'(err_flag_led), 64'(m_flag));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c0, c1, seen;
    logic [7:0]  base;
    logic        ok;
    vec_t        v;

    vecs[0] = '{28'h0000010, 4'h1, 4'd3,  1'b0, 0, 1'b0, 2'b00, 1'b0, 32'h0000_0020};
    vecs[1] = '{28'h0000ABC, 4'h2, 4'd0,  1'b1, 0, 1'b0, 2'b00, 1'b0, 32'h0000_1578};
    vecs[2] = '{28'h00001F0, 4'h5, 4'd5,  1'b0, 5, 1'b1, 2'b00, 1'b0, 32'h0000_03E0};
    vecs[3] = '{28'hFFFFFFF, 4'hF, 4'd15, 1'b0, 2, 1'b1, 2'b00, 1'b0, 32'h1FFF_FFFE};
    vecs[4] = '{28'h0000040, 4'h3, 4'd1,  1'b1, 1, 1'b0, 2'b00, 1'b0, 32'h0000_0080};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_wlast", 64'(axi_wlast), 64'd0);
    chk("rst_wdata", axi_wdata, 64'd0);
    chk("rst_awaddr", 64'(axi_awaddr), 64'd0);
    chk("rst_done", 64'(write_done_p), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_flag", 64'(err_flag_led), 64'd0);
    chk("rst_awsize", 64'(axi_awsize), 64'd3);
    chk("rst_awburst", 64'(axi_awburst), 64'd1);
    chk("rst_wstrb", 64'(axi_wstrb), 64'hFF);
    chk("rst_bready", 64'(axi_bready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_burst(vecs[i], c0, c1);
      if (i == 0) begin
        chk("t1_beat0", c0, 64'h5A49_5A48_5A4B_5A4A);
        chk("t1_beat1", c1, 64'h2D3A_2D3B_2D38_2D39);
        chk("t1_lane1_lo", 64'(c0[23:16]), 64'h4B);
      end
      if (i == 1) chk("t2_pattern", c0, 64'h0000_ffff_0000_ffff);
    end

    // ID mismatch alone counts as a bad response
    v = vecs[1];
    v.pat = 1'b0;
    v.bidbad = 1'b1;
    do_burst(v, c0, c1);
    chk("bid_err_cnt", 64'(err_cnt), 64'd1);

    // Saturation under a stream of SLVERR responses
    v.bidbad = 1'b0;
    v.bresp  = 2'b10;
    for (int n = 0; n < 300; n++) do_burst(v, c0, c1);
    chk("sat_err_cnt", 64'(err_cnt), 64'hFF);
    chk("sat_err_flag", 64'(err_flag_led), 64'd1);

    // Reset during beat 2 of an 8-beat burst
    v = vecs[0];
    v.len = 4'd7;
    base = v.addr[7:0];
    start_burst(v);
    do_beat(v, 0, base, seen, ok);
    do_beat(v, 1, base, seen, ok);
    chk("pre_rst_wvalid", 64'(axi_wvalid), 64'd1);
    rst = 1'b1;
    #1;
    m_lfsr = 8'h5A;
    m_err  = 8'h00;
    m_flag = 1'b0;
    chk("arst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("arst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("arst_done", 64'(write_done_p), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt), 64'd0);
    chk("arst_err_flag", 64'(err_flag_led), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_burst(vecs[0], c0, c1);
    chk("post_rst_seed", c0, 64'h5A49_5A48_5A4B_5A4A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
